// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter.
// Frames are start bit, DATA_BITS payload bits sent LSB first, an optional
// even-parity bit and one stop bit. Every bit lasts DIVISOR clk cycles.
// The transmitter starts a new frame from the FIFO head without an idle gap.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 100000000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    input  logic                          parity_enable,
    output logic                          wr_ready,
    output logic                          tx_pin,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [2:0]                    fsm_state
);

    // Clock cycles per line bit, rounded to nearest.
    localparam int DIVISOR = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int TMR_W   = (DIVISOR > 2) ? $clog2(DIVISOR) : 2;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DIVISOR - 1);
    localparam logic [TMR_W-1:0] TMR_DONE = TMR_W'(DIVISOR - 2);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    // Reject configurations the bit timer or FIFO pointers cannot support.
    generate
        if (DIVISOR < 4) begin : g_bad_divisor
            $fatal(1, "uart_tx_fifo: DIVISOR must be at least 4");
        end
        if (CLK_FREQ > 100000000) begin : g_bad_clk
            $fatal(1, "uart_tx_fifo: CLK_FREQ above 100 MHz");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
            $fatal(1, "uart_tx_fifo: DATA_BITS must be 5..8");
        end
        if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $fatal(1, "uart_tx_fifo: FIFO_DEPTH must be a power of 2 in 2..64");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                 state;
    logic [TMR_W-1:0]       timer;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_en;
    logic                   par_bit;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [DATA_BITS-1:0]   head;

    logic                   push;
    logic                   pop;
    logic                   bit_end;
    logic                   queued;

    // Write handshake: a byte is taken on a rising edge where wr_valid and
    // wr_ready are both 1. wr_ready depends only on the registered count, so
    // a full FIFO refuses the byte even if the transmitter pops that edge.
    assign wr_ready  = (fifo_count < CNT_FULL);
    assign push      = wr_valid && wr_ready;
    assign queued    = (fifo_count != '0);
    assign bit_end   = (timer == TMR_LAST);
    assign head      = mem[rd_ptr];
    assign fsm_state = state;

    // The transmitter takes the head either from IDLE or at the end of a
    // stop bit, so back-to-back frames have no idle cycle between them.
    assign pop = queued && ((state == IDLE) || ((state == STOP) && bit_end));

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data[DATA_BITS-1:0];
        end
    end

    // FIFO pointers and occupancy (excludes the byte being transmitted).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Overflow flags a refused write for exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else begin
            overflow <= wr_valid && !wr_ready;
        end
    end

    // Frame sequencer: bit timing, shift register and registered line outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_en  <= 1'b0;
            par_bit <= 1'b0;
            tx_pin  <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            // Raised for the final cycle of the stop bit only.
            tx_done <= (state == STOP) && (timer == TMR_DONE);

            case (state)
                IDLE: begin
                    timer <= '0;
                    if (pop) begin
                        shreg   <= head;
                        par_en  <= parity_enable;
                        par_bit <= ^head;
                        bit_idx <= '0;
                        tx_pin  <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= START;
                    end else begin
                        tx_pin  <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                end

                START: begin
                    if (bit_end) begin
                        timer  <= '0;
                        tx_pin <= shreg[0];
                        state  <= DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (bit_idx == BIT_LAST) begin
                            if (par_en) begin
                                tx_pin <= par_bit;
                                state  <= PARITY;
                            end else begin
                                tx_pin <= 1'b1;
                                state  <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= shreg >> 1;
                            tx_pin  <= shreg[1];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        timer  <= '0;
                        tx_pin <= 1'b1;
                        state  <= STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (pop) begin
                            shreg   <= head;
                            par_en  <= parity_enable;
                            par_bit <= ^head;
                            bit_idx <= '0;
                            tx_pin  <= 1'b0;
                            tx_busy <= 1'b1;
                            state   <= START;
                        end else begin
                            tx_pin  <= 1'b1;
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    timer   <= '0;
                    tx_pin  <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at DIVISOR = 10, FIFO_DEPTH = 8.
// Expected line activity is built from the frame format (start, data LSB
// first, optional even parity, stop, each held D cycles) in a queue of
// {busy, pin} per clock cycle.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ  = 1152000;
    localparam int BAUD_RATE = 115200;
    localparam int D         = 10;
    localparam int DEPTH     = 8;

    logic       clk;
    logic       reset;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       parity_enable;
    logic       wr_ready;
    logic       tx_pin;
    logic       tx_busy;
    logic       tx_done;
    logic [3:0] fifo_count;
    logic       overflow;
    logic [2:0] fsm_state;

    int n_tests;
    int n_fail;

    logic [1:0] exp_q[$];

    uart_tx_fifo #(
        .DATA_BITS  (8),
        .BAUD_RATE  (BAUD_RATE),
        .CLK_FREQ   (CLK_FREQ),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .parity_enable (parity_enable),
        .wr_ready      (wr_ready),
        .tx_pin        (tx_pin),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .fsm_state     (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Appends one whole frame to the expected {busy, pin} queue.
    function automatic void add_frame(input logic [7:0] data, input logic par);
        logic [7:0] d;
        d = data;
        for (int c = 0; c < D; c++) exp_q.push_back(2'b10);
        for (int b = 0; b < 8; b++)
            for (int c = 0; c < D; c++) exp_q.push_back({1'b1, d[b]});
        if (par)
            for (int c = 0; c < D; c++) exp_q.push_back({1'b1, ^d});
        for (int c = 0; c < D; c++) exp_q.push_back(2'b11);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++;
        if (tx_pin !== 1'b1 || wr_ready !== 1'b1 || tx_busy !== 1'b0 ||
            fifo_count !== 4'd0 || tx_done !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: pin=%b ready=%b busy=%b count=%0d done=%b ovf=%b, required 1 1 0 0 0 0",
                     tx_pin, wr_ready, tx_busy, fifo_count, tx_done, overflow);
        end
        reset = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            n_tests++;
            if (tx_pin !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_quiet cycle %0d: pin=%b busy=%b count=%0d, required 1 0 0",
                         k, tx_pin, tx_busy, fifo_count);
            end
        end
    endtask

    // Writes one byte into an empty, idle FIFO and checks the whole frame.
    task automatic send_frame(input logic [7:0] data, input logic par,
                              input logic drop_par, input string name);
        logic [1:0] e;
        int len;
        exp_q.delete();
        add_frame(data, par);
        len = exp_q.size();
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data = data;
        parity_enable = par;
        @(negedge clk);
        wr_valid = 1'b0;
        n_tests++;
        if (tx_pin !== 1'b1 || fifo_count !== 4'd1) begin
            n_fail++;
            $display("FAIL %s after_write: pin=%b count=%0d, required 1 1", name, tx_pin, fifo_count);
        end
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (drop_par && k == 20) parity_enable = ~par;
            e = exp_q.pop_front();
            n_tests++;
            if (tx_pin !== e[0] || tx_busy !== e[1]) begin
                n_fail++;
                $display("FAIL %s line cycle %0d: pin=%b busy=%b, required %b %b",
                         name, k, tx_pin, tx_busy, e[0], e[1]);
            end
            n_tests++;
            if (tx_done !== (k == len)) begin
                n_fail++;
                $display("FAIL %s tx_done cycle %0d: got %b, required %b", name, k, tx_done, (k == len));
            end
        end
        @(negedge clk);
        n_tests++;
        if (tx_pin !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || fifo_count !== 4'd0) begin
            n_fail++;
            $display("FAIL %s end_of_frame: pin=%b busy=%b done=%b count=%0d, required 1 0 0 0",
                     name, tx_pin, tx_busy, tx_done, fifo_count);
        end
    endtask

    task automatic test_a5_no_parity();
        send_frame(8'hA5, 1'b0, 1'b0, "a5_no_parity");
    endtask

    task automatic test_07_parity();
        send_frame(8'h07, 1'b1, 1'b1, "07_parity_drop");
    endtask

    task automatic test_random_frames();
        logic [7:0] d;
        logic p;
        logic drop;
        send_frame(8'h00, 1'b1, 1'b0, "zero_parity");
        send_frame(8'hFF, 1'b1, 1'b0, "ff_parity");
        for (int n = 0; n < 6; n++) begin
            d = 8'($urandom_range(0, 255));
            p = 1'($urandom_range(0, 1));
            drop = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 4)) @(negedge clk);
            send_frame(d, p, drop, "random_frame");
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [10];
        logic par;
        logic [1:0] e;
        int done_cnt;
        int accepted;
        int exp_cnt;
        par = 1'($urandom_range(0, 1));
        for (int i = 0; i < 10; i++) d[i] = 8'($urandom_range(0, 255));
        exp_q.delete();
        exp_q.push_back(2'b01);
        for (int f = 0; f < 9; f++) add_frame(d[f], par);
        exp_q.push_back(2'b01);
        done_cnt = 0;

        @(negedge clk);
        wr_valid = 1'b1;
        wr_data = d[0];
        parity_enable = par;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 9) wr_data = d[i+1];
            else wr_valid = 1'b0;
            accepted = (i + 1 < 9) ? i + 1 : 9;
            exp_cnt = accepted - ((i >= 1) ? 1 : 0);
            n_tests++;
            if (fifo_count !== 4'(exp_cnt) || wr_ready !== (exp_cnt < DEPTH)) begin
                n_fail++;
                $display("FAIL b2b write %0d: count=%0d ready=%b, required %0d %b",
                         i + 1, fifo_count, wr_ready, exp_cnt, (exp_cnt < DEPTH));
            end
            n_tests++;
            if (overflow !== (i == 9)) begin
                n_fail++;
                $display("FAIL b2b overflow write %0d: got %b, required %b", i + 1, overflow, (i == 9));
            end
            e = exp_q.pop_front();
            n_tests++;
            if (tx_pin !== e[0] || tx_busy !== e[1]) begin
                n_fail++;
                $display("FAIL b2b line write %0d: pin=%b busy=%b, required %b %b",
                         i + 1, tx_pin, tx_busy, e[0], e[1]);
            end
            if (tx_done === 1'b1) done_cnt++;
        end

        @(negedge clk);
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b overflow_pulse_width: got %b, required 0", overflow);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            if (k > 0) @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (tx_pin !== e[0] || tx_busy !== e[1]) begin
                n_fail++;
                $display("FAIL b2b line cycle %0d: pin=%b busy=%b, required %b %b",
                         k, tx_pin, tx_busy, e[0], e[1]);
            end
            if (tx_done === 1'b1) done_cnt++;
        end
        n_tests++;
        if (done_cnt !== 9) begin
            n_fail++;
            $display("FAIL b2b tx_done_count: got %0d, required 9", done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d [5];
        logic [7:0] first;
        for (int i = 0; i < 5; i++) d[i] = 8'($urandom_range(0, 255));
        first = d[0];
        @(negedge clk);
        parity_enable = 1'b0;
        wr_valid = 1'b1;
        wr_data = d[0];
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            wr_data = d[i];
        end
        @(negedge clk);
        wr_valid = 1'b0;
        n_tests++;
        if (fifo_count !== 4'd4) begin
            n_fail++;
            $display("FAIL reset_mid queued: count=%0d, required 4", fifo_count);
        end
        // Now 4 cycles into the frame; data bit 3 occupies cycles 41..50.
        repeat (41) @(negedge clk);
        n_tests++;
        if (tx_pin !== first[3] || tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid bit3: pin=%b busy=%b, required %b 1", tx_pin, tx_busy, first[3]);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (tx_pin !== 1'b1 || fifo_count !== 4'd0 || tx_busy !== 1'b0 ||
            wr_ready !== 1'b1 || tx_done !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid immediate: pin=%b count=%0d busy=%b ready=%b done=%b ovf=%b, required 1 0 0 1 0 0",
                     tx_pin, fifo_count, tx_busy, wr_ready, tx_done, overflow);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            n_tests++;
            if (tx_pin !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_mid quiet cycle %0d: pin=%b busy=%b count=%0d, required 1 0 0",
                         k, tx_pin, tx_busy, fifo_count);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        reset = 1'b1;
        wr_valid = 1'b0;
        wr_data = 8'h00;
        parity_enable = 1'b0;

        test_reset();
        test_a5_no_parity();
        test_07_parity();
        test_random_frames();
        test_back_to_back();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
